// File: rtl/reg8_pkg.sv
// Shared types and defaults for the reg8 pipeline register.
package reg8_pkg;

   localparam int REG8_WIDTH = 8;

   typedef logic [REG8_WIDTH-1:0] reg8_data_t;

   localparam reg8_data_t REG8_RST_VAL = '0;

   localparam int REG8_MAX_DEPTH = 16;

endpackage : reg8_pkg

// File: rtl/reg8_stage.sv
// One pipeline stage: a data flop plus its valid flop, with hold and synchronous clear.
module reg8_stage
   import reg8_pkg::*;
#(
   parameter int               WIDTH   = REG8_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] q_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   // Clear beats enable, so a datum presented alongside clr is dropped.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr) begin
         data_d  = RST_VAL;
         valid_d = 1'b0;
      end else if (en) begin
         data_d  = d_i;
         valid_d = valid_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= RST_VAL;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign q_o     = data_q;
   assign valid_o = valid_q;

endmodule : reg8_stage

// File: rtl/reg8.sv
// Parameterised pipeline register: D reaches Q after DEPTH enabled clock edges.
module reg8
   import reg8_pkg::*;
#(
   parameter int               WIDTH   = REG8_WIDTH,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             q_valid
);

   if (DEPTH < 1 || DEPTH > REG8_MAX_DEPTH) begin : g_bad_depth
      $error("reg8: DEPTH must be in 1..16");
   end

   // Index 0 is the input side; index DEPTH is the last stage's output.
   logic [WIDTH-1:0] data_chain  [0:DEPTH];
   logic             valid_chain [0:DEPTH];

   assign data_chain[0]  = D;
   assign valid_chain[0] = 1'b1;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      reg8_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .clr     (clr),
         .d_i     (data_chain[gi]),
         .valid_i (valid_chain[gi]),
         .q_o     (data_chain[gi+1]),
         .valid_o (valid_chain[gi+1])
      );
   end

   assign Q       = data_chain[DEPTH];
   assign q_valid = valid_chain[DEPTH];

endmodule : reg8

// File: tb/tb_reg8.sv
// Directed bench for reg8 at DEPTH=1, DEPTH=3 and DEPTH=4/WIDTH=16.
module tb_reg8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic        clr = 1'b0;
   logic [7:0]  d8  = 8'hA5;
   logic [15:0] d16 = 16'h0000;

   logic [7:0]  q1, q3;
   logic [15:0] q4;
   logic        v1, v3, v4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg8 #(.WIDTH(8), .DEPTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .D(d8), .Q(q1), .q_valid(v1)
   );

   reg8 #(.WIDTH(8), .DEPTH(3)) u_dut3 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .D(d8), .Q(q3), .q_valid(v3)
   );

   reg8 #(.WIDTH(16), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .D(d16), .Q(q4), .q_valid(v4)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: %h", tag, obs);
      end
   endtask

   // Advance past the next rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with the clock running and D non-zero.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_q", q1, 8'h00);
         check("rst_valid", v1, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      d8  = 8'h3C;
      tick();
      check("first_load_q", q1, 8'h3C);
      check("first_load_valid", v1, 1'b1);

      // Streaming through the single-stage register.
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         d8 = 8'(i);
         tick();
         check("stream", q1, 16'(i));
      end

      // Hold while disabled.
      @(negedge clk);
      d8 = 8'h5A;
      tick();
      check("hold_load", q1, 8'h5A);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         en = 1'b0;
         d8 = (i % 2 == 0) ? 8'hFF : 8'h00;
         tick();
         check("hold", q1, 8'h5A);
      end
      @(negedge clk);
      en = 1'b1;
      d8 = 8'h11;
      tick();
      check("reenable", q1, 8'h11);

      // Clear has priority over enable.
      @(negedge clk);
      d8 = 8'h77;
      tick();
      check("pre_clr", q1, 8'h77);
      @(negedge clk);
      clr = 1'b1;
      d8  = 8'h99;
      tick();
      check("clr_q", q1, 8'h00);
      check("clr_valid", v1, 1'b0);
      @(negedge clk);
      clr = 1'b0;
      tick();
      check("post_clr_q", q1, 8'h99);
      check("post_clr_valid", v1, 1'b1);

      // DEPTH=3: fill, then asynchronous reset between edges.
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         d8 = 8'(i * 16);
         tick();
      end
      check("d3_fill_q", q3, 8'h10);
      check("d3_fill_valid", v3, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("d3_async_q", q3, 8'h00);
      check("d3_async_valid", v3, 1'b0);
      check("d1_async_q", q1, 8'h00);
      #2;
      rst = 1'b0;
      d8  = 8'h44;
      tick();
      check("d3_reload1_valid", v3, 1'b0);
      @(negedge clk);
      d8 = 8'h55;
      tick();
      check("d3_reload2_valid", v3, 1'b0);
      @(negedge clk);
      d8 = 8'h66;
      tick();
      check("d3_reload3_q", q3, 8'h44);
      check("d3_reload3_valid", v3, 1'b1);

      // DEPTH=4, WIDTH=16: single pulse appears exactly four edges later.
      @(negedge clk);
      d16 = 16'hBEEF;
      tick();
      check("d4_lat1", q4, 16'h0000);
      @(negedge clk);
      d16 = 16'h0000;
      tick();
      check("d4_lat2", q4, 16'h0000);
      tick();
      check("d4_lat3", q4, 16'h0000);
      tick();
      check("d4_lat4", q4, 16'hBEEF);
      check("d4_valid", v4, 1'b1);
      tick();
      check("d4_lat5", q4, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_reg8
